instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Inverse of the TinyCPU instruction decoder: accepts field-level instruction tuples over a valid/ready stream and packs each into the 32-bit TinyCPU word. Writes the words sequentially into instruction memory from a programmable base address. Used by the test harness and boot loader to build programs in IMEM without hand-assembled hex.

Parameters:
ADDR_W, 8, IMEM word-address width; capacity 2^ADDR_W words

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: begin program load at base_addr; ignored while busy
base_addr  input  ADDR_W  first IMEM word address, sampled on accepted start
in_valid  input  1  field tuple valid
in_ready  output  1  tuple accepted when in_valid && in_ready
in_type  input  5  instruction type, placed at [31:27]
in_reg_a  input  5  imm: dest reg; mem: address reg; alu: operand 0
in_reg_b  input  5  mem: dest reg; alu: operand 1
in_reg_c  input  5  alu: result reg
in_imm  input  32  immediate; only [15:0] encodable
in_last  input  1  final tuple of program
mem_wr_valid  output  1  IMEM write request
mem_wr_ready  input  1  IMEM accepts write
mem_wr_addr  output  ADDR_W  IMEM word address
mem_wr_data  output  32  encoded instruction
busy  output  1  high in LOAD and DRAIN
done  output  1  one-cycle pulse when load completes
word_count  output  ADDR_W+1  words written in current/last load
error  output  1  sticky until next accepted start

Behaviour:
- Reset: all outputs 0; state IDLE; address counter 0; full flag 0.
- Encoding by type class; unused bits 0:
  - type 0 (NOOP): word = 0.
  - type 1 (LOAD_IMM): [26:11]=in_imm[15:0], [10:6]=reg_a.
  - types 2-3 (LOAD_MEM/STORE): [26:22]=reg_a, [21:17]=reg_b.
  - types 4-31 (ALU): [26:22]=reg_a, [21:17]=reg_b, [16:12]=reg_c.
- States:
  - IDLE: start -> LOAD; addr<=base_addr, word_count<=0, error<=0, full<=0.
  - LOAD: accept tuples; accepted with in_last -> DRAIN.
  - DRAIN: when output register empty or its write is handshaken this cycle -> IDLE, done=1 that cycle.
- in_ready = (state==LOAD) && (!mem_wr_valid || mem_wr_ready).
- Output register: single stage. Tuple accepted in cycle N gives mem_wr_valid/addr/data in cycle N+1. These hold stable until mem_wr_ready. Full throughput of 1 word/cycle while mem_wr_ready=1.
- Address increments on each accepted non-dropped tuple.
- After writing address 2^ADDR_W-1, full<=1 and the counter does not wrap.
- Tuples accepted while full: dropped (no write, no count), error<=1; in_last still terminates.
- in_imm[31:16]!=0 on a type-1 tuple: word written with truncated imm, error<=1.
- start during LOAD/DRAIN ignored. start and the final write in the same DRAIN cycle: start ignored.
- Async reset mid-load: immediate return to reset state; a pending write is discarded (mem_wr_valid falls asynchronously).

Optional Feature:
ENCODER_CHECKSUM_EN.
- Defined: adds output checksum[31:0], the XOR of all words written since the last accepted start. Cleared on start and reset. Final value is valid in the done cycle and held until the next start.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package tinycpu_isa_pkg, shared with the decoder:
  - type codes TYPE_NOOP=0, TYPE_LOAD_IMM=1, TYPE_LOAD_MEM=2, TYPE_STORE=3, TYPE_ALU_BASE=4;
  - field MSB/LSB constants for type, imm, reg slots;
  - state enum.
- Sub-module instr_field_packer: purely combinational tuple-to-word packing, reusable by the assembler model.

Test Plan:
- start base=0x10; one tuple type1 imm=0x1234 a=5 last=1 -> single write addr 0x10 data 0x0891A140; done one cycle later; word_count=1; error=0.
- Stream type4 a=1 b=2 c=3 then type2 a=7 b=9 last, back-to-back, mem_wr_ready=1 -> data 0x20443000 @0x10 and 0x11D20000 @0x11 on consecutive cycles.
- mem_wr_ready low 3 cycles mid-stream -> in_ready low, mem_wr_* held stable, no word lost or duplicated.
- ADDR_W=8, base=0xFE, 4 tuples -> writes at 0xFE and 0xFF only; error=1; word_count=2; done asserted.
- type1 with in_imm=0x0001_0005 -> data imm field 0x0005, error=1; next start clears error.
- Assert rst_n low during DRAIN with mem_wr_ready=0 -> mem_wr_valid=0 immediately; done never pulses; IDLE after release.

Source files
------------

// File: rtl/tinycpu_isa_pkg.sv
// tinycpu_isa_pkg: TinyCPU type codes, instruction field positions and loader state
// encoding, shared with the decoder.
package tinycpu_isa_pkg;
    localparam logic [4:0] TYPE_NOOP     = 5'd0;
    localparam logic [4:0] TYPE_LOAD_IMM = 5'd1;
    localparam logic [4:0] TYPE_LOAD_MEM = 5'd2;
    localparam logic [4:0] TYPE_STORE    = 5'd3;
    localparam logic [4:0] TYPE_ALU_BASE = 5'd4;

    localparam int TYPE_MSB   = 31;
    localparam int TYPE_LSB   = 27;
    localparam int IMM_MSB    = 26;
    localparam int IMM_LSB    = 11;
    localparam int IMM_RA_MSB = 10;
    localparam int IMM_RA_LSB = 6;
    localparam int RA_MSB     = 26;
    localparam int RA_LSB     = 22;
    localparam int RB_MSB     = 21;
    localparam int RB_LSB     = 17;
    localparam int RC_MSB     = 16;
    localparam int RC_LSB     = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: packs one TinyCPU field tuple into its 32-bit instruction word.
module instr_field_packer
    import tinycpu_isa_pkg::*;
(
    input  logic [4:0]  i_type,
    input  logic [4:0]  i_reg_a,
    input  logic [4:0]  i_reg_b,
    input  logic [4:0]  i_reg_c,
    input  logic [15:0] i_imm,
    output logic [31:0] o_word
);
    always_comb begin
        o_word = '0;
        if (i_type == TYPE_LOAD_IMM) begin
            o_word[TYPE_MSB:TYPE_LSB]     = i_type;
            o_word[IMM_MSB:IMM_LSB]       = i_imm;
            o_word[IMM_RA_MSB:IMM_RA_LSB] = i_reg_a;
        end else if (i_type != TYPE_NOOP) begin
            o_word[TYPE_MSB:TYPE_LSB] = i_type;
            o_word[RA_MSB:RA_LSB]     = i_reg_a;
            o_word[RB_MSB:RB_LSB]     = i_reg_b;
            if (i_type >= TYPE_ALU_BASE)
                o_word[RC_MSB:RC_LSB] = i_reg_c;
        end
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes field tuples and writes them sequentially into IMEM.
// Define ENCODER_CHECKSUM_EN to add a running XOR checksum output of written words.
module instr_encoder_loader
    import tinycpu_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_type,
    input  logic [4:0]        in_reg_a,
    input  logic [4:0]        in_reg_b,
    input  logic [4:0]        in_reg_c,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              error
`ifdef ENCODER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);
    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_full;
    logic                r_wr_valid;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
    logic [ADDR_W:0]     r_count;
    logic                r_error;
    logic [31:0]         r_cksum;
    logic [31:0]         w_word;
    logic                w_accept;
    logic                w_fire_out;

    instr_field_packer u_packer (
        .i_type  (in_type),
        .i_reg_a (in_reg_a),
        .i_reg_b (in_reg_b),
        .i_reg_c (in_reg_c),
        .i_imm   (in_imm[15:0]),
        .o_word  (w_word)
    );

    assign in_ready     = (r_state == ST_LOAD) && (!r_wr_valid || mem_wr_ready);
    assign w_accept     = in_valid && in_ready;
    assign w_fire_out   = r_wr_valid && mem_wr_ready;
    assign mem_wr_valid = r_wr_valid;
    assign mem_wr_addr  = r_wr_addr;
    assign mem_wr_data  = r_wr_data;
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DRAIN) && (!r_wr_valid || mem_wr_ready);
    assign word_count   = r_count;
    assign error        = r_error;
`ifdef ENCODER_CHECKSUM_EN
    assign checksum     = r_cksum;
`endif

    // Words are folded into the checksum on entry to the output register, so the
    // final write is already included in the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_full     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_count    <= '0;
            r_error    <= 1'b0;
            r_cksum    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_state <= ST_LOAD;
                    r_addr  <= base_addr;
                    r_count <= '0;
                    r_error <= 1'b0;
                    r_full  <= 1'b0;
                    r_cksum <= '0;
                end
                ST_LOAD:  if (w_accept && in_last) r_state <= ST_DRAIN;
                ST_DRAIN: if (done) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
            if (w_accept) begin
                if (r_full) begin
                    r_error <= 1'b1;
                end else begin
                    r_wr_addr <= r_addr;
                    r_wr_data <= w_word;
                    r_cksum   <= r_cksum ^ w_word;
                    r_count   <= r_count + 1'b1;
                    if (&r_addr) r_full <= 1'b1;
                    else r_addr <= r_addr + 1'b1;
                    if (in_type == TYPE_LOAD_IMM && |in_imm[31:16]) r_error <= 1'b1;
                end
            end
            r_wr_valid <= (w_accept && !r_full) ? 1'b1 : (w_fire_out ? 1'b0 : r_wr_valid);
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: scoreboard bench for instr_encoder_loader; directed vectors
// push expected IMEM writes, a monitor pops and compares each handshaken write.
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_type = '0, in_reg_a = '0, in_reg_b = '0, in_reg_c = '0;
    logic [31:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        mem_wr_valid;
    logic        mem_wr_ready = 1'b1;
    logic [7:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        busy, done, error;
    logic [8:0]  word_count;

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];
    logic        hold_v = 1'b0;
    logic [7:0]  hold_a;
    logic [31:0] hold_d;

    instr_encoder_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_reg_a(in_reg_a), .in_reg_b(in_reg_b), .in_reg_c(in_reg_c),
        .in_imm(in_imm), .in_last(in_last), .mem_wr_valid(mem_wr_valid),
        .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .busy(busy), .done(done),
        .word_count(word_count), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every handshaken write and checks stalled outputs stay put.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_v)
                chk("stall_hold", {mem_wr_valid, mem_wr_addr, mem_wr_data}, {1'b1, hold_a, hold_d});
            hold_v = mem_wr_valid && !mem_wr_ready;
            hold_a = mem_wr_addr;
            hold_d = mem_wr_data;
            if (mem_wr_valid && mem_wr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", mem_wr_addr, mem_wr_data);
                end else begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    chk("write", {mem_wr_addr, mem_wr_data}, e);
                end
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic do_start(input logic [7:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] t, a, b, c, input logic [31:0] imm, input logic last,
                        input logic exp_w, input logic [7:0] ea, input logic [31:0] ed, output int waited);
        logic got;
        in_valid = 1'b1; in_type = t; in_reg_a = a; in_reg_b = b; in_reg_c = c;
        in_imm = imm; in_last = last;
        waited = 0;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
            waited++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end else if (exp_w) exp_q.push_back({ea, ed});
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [8:0] ecount, input logic eerr, output int n);
        logic got;
        got = 1'b0;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
            n++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_done_timeout: got done 0 expected 1", name);
        end else begin
            chk({name, "_count"}, word_count, ecount);
            chk({name, "_error"}, error, eerr);
            @(negedge clk);
            chk({name, "_idle"}, {busy, done}, 2'b00);
        end
    endtask

    initial begin
        int w, n;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {in_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, busy, done, word_count, error}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single LOAD_IMM word
        do_start(8'h10);
        chk("busy_after_start", busy, 1'b1);
        send(5'd1, 5'd5, 5'd0, 5'd0, 32'h1234, 1'b1, 1'b1, 8'h10, 32'h0891A140, w);
        wait_done("single", 9'd1, 1'b0, n);
        chk("single_done_latency", n, 0);

        // Back-to-back ALU then LOAD_MEM
        do_start(8'h10);
        send(5'd4, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b1, 8'h10, 32'h20443000, w);
        send(5'd2, 5'd7, 5'd9, 5'd0, 32'h0, 1'b1, 1'b1, 8'h11, 32'h11D20000, n);
        chk("b2b_no_wait", w + n, 0);
        wait_done("b2b", 9'd2, 1'b0, n);

        // Back-pressure mid-stream
        do_start(8'h50);
        send(5'd5, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 1'b1, 8'h50, 32'h28421000, w);
        mem_wr_ready = 1'b0;
        in_valid = 1'b1; in_type = 5'd3; in_reg_a = 5'd2; in_reg_b = 5'd3;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out", {mem_wr_valid, mem_wr_addr, mem_wr_data}, {1'b1, 8'h50, 32'h28421000});
        end
        @(posedge clk); #1;
        mem_wr_ready = 1'b1;
        send(5'd3, 5'd2, 5'd3, 5'd0, 32'h0, 1'b0, 1'b1, 8'h51, 32'h18860000, w);
        send(5'd0, 5'd9, 5'd9, 5'd9, 32'hFFFF, 1'b1, 1'b1, 8'h52, 32'h0, w);
        wait_done("stall", 9'd3, 1'b0, n);

        // Top-of-memory: no wrap, extra tuples dropped
        do_start(8'hFE);
        send(5'd4, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b1, 8'hFE, 32'h20443000, w);
        send(5'd4, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b1, 8'hFF, 32'h20443000, w);
        send(5'd4, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, w);
        send(5'd4, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 1'b0, 8'h00, 32'h0, w);
        wait_done("full", 9'd2, 1'b1, n);

        // Oversized immediate truncated and flagged; next start clears the flag
        do_start(8'h20);
        send(5'd1, 5'd0, 5'd0, 5'd0, 32'h0001_0005, 1'b1, 1'b1, 8'h20, 32'h08002800, w);
        wait_done("imm_trunc", 9'd1, 1'b1, n);
        do_start(8'h20);
        chk("error_cleared", error, 1'b0);
        send(5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 8'h20, 32'h0, w);
        wait_done("after_err", 9'd1, 1'b0, n);

        // Async reset during DRAIN with a pending write
        do_start(8'h30);
        mem_wr_ready = 1'b0;
        send(5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1, 8'h30, 32'h0, w);
        @(negedge clk);
        chk("drain_pending", {busy, mem_wr_valid, done}, 3'b110);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset", {busy, mem_wr_valid, in_ready}, 3'b000);
        repeat (3) begin
            @(negedge clk);
            chk("reset_no_done", done, 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_wr_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {busy, mem_wr_valid, done, word_count}, '0);
        do_start(8'h40);
        send(5'd1, 5'd1, 5'd0, 5'd0, 32'h7, 1'b1, 1'b1, 8'h40, 32'h08003840, w);
        wait_done("post_reset", 9'd1, 1'b0, n);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
